wb_drain: RTL and testbench

Write-buffer drain controller sitting directly downstream of the 32-entry, 32-bit write FIFO in the cache write path. It pops address/data word pairs from the FIFO, checks each address, and issues single-word writes to the memory interface over a valid/ready handshake. It also supports a flush request that reports when the buffer is fully drained. Each memory write leaves through one outstanding-request register, so the FIFO absorbs all back-pressure.

---
 rtl/wb_drain_pkg.sv | 20 ++
 rtl/wb_drain_sat_counter.sv | 32 +++
 rtl/wb_drain.sv | 114 +++++++++++
 tb/tb_wb_drain.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_drain_pkg.sv
// wb_drain_pkg: shared types and constants for the write-buffer drain controller.
package wb_drain_pkg;

  localparam int FIFO_W = 32;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    POP_A,
    CAP_A,
    POP_D,
    CAP_D,
    REQ
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/wb_drain_sat_counter.sv
// wb_sat_counter: W-bit up-counter that sticks at all-ones; clear wins over inc.
module wb_sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/wb_drain.sv
// wb_drain: pops address/data pairs from the write FIFO and issues single-word
// memory writes over a valid/ready handshake. Misaligned addresses are dropped.
// Build option: define WB_DRAIN_COUNT_EN to implement drained_count; otherwise
// it is tied to zero.
//
// state | meaning
// IDLE  | waiting for the FIFO to hold an entry
// POP_A | pop strobe for the address word
// CAP_A | address word on fifo_data, captured
// POP_D | pop strobe for the data word (waits here while FIFO is empty)
// CAP_D | data word captured, alignment checked
// REQ   | mem_req held until mem_ready
module wb_drain
  import wb_drain_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              fifo_empty,
  input  logic [FIFO_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              fifo_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              flush,
  output logic              flush_done,
  output logic              busy,
  output logic              err_misalign,
  output logic [CNT_W-1:0]  drained_count
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_req_q, mem_req_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  // Next state, capture registers, and outputs registered to line up with the new state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE:  if (!fifo_empty) state_d = POP_A;
      POP_A: state_d = CAP_A;
      CAP_A: begin
        addr_d  = fifo_data[ADDR_W-1:0];
        state_d = POP_D;
      end
      POP_D: if (!fifo_empty) state_d = CAP_D;
      CAP_D: begin
        wdata_d = fifo_data[DATA_W-1:0];
        state_d = is_misaligned(addr_q[1:0]) ? IDLE : REQ;
      end
      REQ:   if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_req_d = (state_d == REQ);
    busy_d    = (state_d != IDLE);
    // addr_q is already stable on the POP_D->CAP_D step, so the pulse lands in CAP_D.
    err_d     = (state_d == CAP_D) && is_misaligned(addr_q[1:0]);
  end

  // State and output registers; reset discards any captured, unissued pair.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mem_req_q <= mem_req_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  // The pop strobe must see the live empty flag so a split pair never over-reads.
  assign fifo_rd      = !Rst && ((state_q == POP_A) || (state_q == POP_D)) && !fifo_empty;
  assign fifo_en      = 1'b1;
  assign mem_req      = mem_req_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign busy         = busy_q;
  assign err_misalign = err_q;
  assign flush_done   = !Rst && flush && fifo_empty && (state_q == IDLE);

`ifdef WB_DRAIN_COUNT_EN
  logic xfer;
  assign xfer = mem_req_q && mem_ready;

  wb_sat_counter #(.W(CNT_W)) u_drained_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (xfer),
    .clear (1'b0),
    .count (drained_count)
  );
`else
  assign drained_count = '0;
`endif

endmodule

// File: tb/tb_wb_drain.sv
// tb_wb_drain: directed, table-driven bench for wb_drain with a behavioural FIFO
// and a transfer monitor.
module tb_wb_drain;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_data = '0;
  logic        fifo_rd, fifo_en, mem_req, flush_done, busy, err_misalign;
  logic        mem_ready = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] drained_count;

  logic [31:0] fq[$];
  logic [63:0] xq[$];
  int n_cmp = 0, n_fail = 0;
  int pops = 0, rd_viol = 0, xfers = 0, exp_cnt = 0;
  logic rd_prev = 1'b0;

  always #5 Clk = ~Clk;

  wb_drain #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .fifo_rd       (fifo_rd),
    .fifo_en       (fifo_en),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .flush         (flush),
    .flush_done    (flush_done),
    .busy          (busy),
    .err_misalign  (err_misalign),
    .drained_count (drained_count)
  );

  // Behavioural FIFO: data appears the cycle after a pop; flags violations.
  always @(posedge Clk) begin
    if (Rst) begin
      fq.delete();
      fifo_empty <= 1'b1;
      rd_prev = 1'b0;
    end else begin
      if (fifo_rd) begin
        if (fq.size() == 0) rd_viol++;
        else begin
          fifo_data <= fq.pop_front();
          pops++;
        end
        if (rd_prev) rd_viol++;
        fifo_empty <= (fq.size() == 0);
      end
      rd_prev = fifo_rd;
    end
  end

  // Transfer monitor.
  always @(posedge Clk) begin
    if (!Rst && mem_req && mem_ready) begin
      xq.push_back({mem_addr, mem_wdata});
      xfers++;
    end
  end

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_dc();
`ifdef WB_DRAIN_COUNT_EN
    return exp_cnt;
`else
    return 0;
`endif
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
    bit          exp_req;
    bit          exp_err;
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input vec_t v);
    int cyc, req_cyc, stalled, seen_err, unstable, x0, p0;
    logic [63:0] got;
    x0 = xfers; p0 = pops;
    cyc = 0; req_cyc = 0; stalled = 0; seen_err = 0; unstable = 0;
    mem_ready = (v.stall == 0);
    push(v.addr);
    push(v.data);
    do begin
      @(negedge Clk);
      cyc++;
      if (err_misalign) seen_err++;
      if (mem_req) begin
        if (req_cyc == 0) req_cyc = cyc;
        if (mem_addr !== v.addr || mem_wdata !== v.data) unstable++;
        if (!mem_ready) begin
          stalled++;
          if (stalled >= v.stall) mem_ready = 1'b1;
        end
      end
    end while (busy && cyc < 40);
    mem_ready = 1'b1;
    chk("vec_in_time", 64'(cyc < 40), 64'(1));
    chk("vec_req_latency", 64'(req_cyc), v.exp_req ? 64'(5) : 64'(0));
    chk("vec_xfer_count", 64'(xfers - x0), 64'(v.exp_req));
    if (v.exp_req && xq.size() > 0) begin
      got = xq.pop_front();
      chk("vec_xfer_pair", got, {v.addr, v.data});
      exp_cnt++;
    end
    chk("vec_err_pulses", 64'(seen_err), 64'(v.exp_err));
    chk("vec_stable", 64'(unstable), 64'(0));
    chk("vec_stall_len", 64'(stalled), 64'(v.stall));
    chk("vec_pops", 64'(pops - p0), 64'(2));
    chk("vec_drained", 64'(drained_count), 64'(exp_dc()));
  endtask

  initial begin
    int cyc, bad, early, x0;
    logic [63:0] got;

    vt[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b1, 1'b0};
    vt[1] = '{32'h0000_0100, 32'hDEAD_BEEF, 7, 1'b1, 1'b0};
    vt[2] = '{32'h0000_0102, 32'h1234_5678, 0, 1'b0, 1'b1};
    vt[3] = '{32'h8000_0003, 32'hCAFE_F00D, 0, 1'b0, 1'b1};
    vt[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 2, 1'b1, 1'b0};
    vt[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 0, 1'b1, 1'b0};

    // Reset state.
    flush = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_fifo_rd", 64'(fifo_rd), 64'(0));
    chk("rst_fifo_en", 64'(fifo_en), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err_misalign), 64'(0));
    chk("rst_flush_done", 64'(flush_done), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    chk("rst_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_drained", 64'(drained_count), 64'(0));
    Rst = 1'b0;
    @(negedge Clk);
    chk("idle_flush_done", 64'(flush_done), 64'(1));
    flush = 1'b0;
    #1;
    chk("idle_noflush_done", 64'(flush_done), 64'(0));

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Split pair: data word arrives late; FSM must wait in POP_D without popping.
    x0 = xfers; bad = 0;
    push(32'h0000_0200);
    repeat (3) @(negedge Clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (fifo_rd || mem_req || !busy) bad++;
    end
    chk("split_wait", 64'(bad), 64'(0));
    push(32'h0000_0055);
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (busy && cyc < 20);
    chk("split_in_time", 64'(cyc < 20), 64'(1));
    chk("split_xfers", 64'(xfers - x0), 64'(1));
    if (xq.size() > 0) begin
      got = xq.pop_front();
      chk("split_pair", got, {32'h0000_0200, 32'h0000_0055});
      exp_cnt++;
    end
    chk("split_drained", 64'(drained_count), 64'(exp_dc()));

    // Full drain with flush: 16 pairs back to back, one write per 6 cycles.
    x0 = xfers; early = 0; cyc = 0;
    for (int i = 0; i < 16; i++) begin
      push(32'h0000_1000 + 32'(i * 16));
      push(32'hA5A5_0000 + 32'(i));
    end
    flush = 1'b1;
    do begin
      @(negedge Clk);
      cyc++;
      if (flush_done && (xfers - x0) < 16) early++;
    end while (!flush_done && cyc < 200);
    chk("flush_cycles", 64'(cyc), 64'(96));
    chk("flush_early", 64'(early), 64'(0));
    chk("flush_xfers", 64'(xfers - x0), 64'(16));
    for (int i = 0; i < 16; i++) begin
      if (xq.size() > 0) begin
        got = xq.pop_front();
        chk("flush_order", got, {32'h0000_1000 + 32'(i * 16), 32'hA5A5_0000 + 32'(i)});
      end
    end
    exp_cnt += 16;
    chk("flush_drained", 64'(drained_count), 64'(exp_dc()));
    flush = 1'b0;
    #1;
    chk("flush_release", 64'(flush_done), 64'(0));

    // Reset while a request is pending.
    mem_ready = 1'b0;
    push(32'h0000_0300);
    push(32'hAAAA_5555);
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (!mem_req && cyc < 20);
    chk("rstreq_reached", 64'(mem_req), 64'(1));
    Rst = 1'b1;
    @(negedge Clk);
    exp_cnt = 0;
    chk("rstreq_mem_req", 64'(mem_req), 64'(0));
    chk("rstreq_busy", 64'(busy), 64'(0));
    chk("rstreq_drained", 64'(drained_count), 64'(0));
    chk("rstreq_addr", 64'(mem_addr), 64'(0));
    Rst = 1'b0;
    mem_ready = 1'b1;
    x0 = xfers; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (mem_req || busy) bad++;
    end
    chk("rstreq_no_issue", 64'(bad), 64'(0));
    chk("rstreq_xfers", 64'(xfers - x0), 64'(0));

    chk("fifo_rd_protocol", 64'(rd_viol), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
